// File: rtl/buzzer_sequencer.sv
// Tone sequencer for an active-low piezo buzzer.
// Melody mode steps through note codes from an external ROM (optionally looping);
// beep mode sounds a programmed number of fixed-pitch beeps. Runs end with a
// one-cycle done pulse, qualified by aborted when ended by stop.
module buzzer_sequencer #(
    parameter int unsigned CLK_HZ     = 24000000,
    parameter int unsigned NOTE_MS    = 250,
    parameter int unsigned SEQ_LEN    = 64,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned HALF_W     = 17,
    parameter int unsigned BEEP_CODE  = 5,
    parameter logic        IDLE_LEVEL = 1'b1,
    // Derived address width; leave at its default.
    parameter int unsigned AW         = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_mel,
    input  logic             loop_en,
    input  logic             start_beep,
    input  logic [CNT_W-1:0] beep_count,
    input  logic             stop,
    output logic [AW-1:0]    seq_addr,
    input  logic [3:0]       note_code,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] beeps_done,
    output logic             beep
);

    localparam int unsigned NOTE_CYC = CLK_HZ / 1000 * NOTE_MS;
    localparam int unsigned TW       = (NOTE_CYC > 1) ? $clog2(NOTE_CYC) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(NOTE_CYC - 1);
    localparam logic [AW-1:0] ADDR_LAST  = AW'(SEQ_LEN - 1);
    localparam logic [3:0]    CODE_END   = 4'd15;
    localparam logic [3:0]    CODE_REST  = 4'd0;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StPlay,
        StBOn,
        StBOff
    } state_e;

    // Half-period in clock cycles for each note code; 0 for rest and end marker.
    function automatic logic [HALF_W-1:0] half_of(input logic [3:0] code);
        logic [HALF_W-1:0] h;
        case (code)
            4'd1:    h = HALF_W'(CLK_HZ / 660);
            4'd2:    h = HALF_W'(CLK_HZ / 784);
            4'd3:    h = HALF_W'(CLK_HZ / 880);
            4'd4:    h = HALF_W'(CLK_HZ / 988);
            4'd5:    h = HALF_W'(CLK_HZ / 1046);
            4'd6:    h = HALF_W'(CLK_HZ / 1174);
            4'd7:    h = HALF_W'(CLK_HZ / 1318);
            4'd8:    h = HALF_W'(CLK_HZ / 1396);
            4'd9:    h = HALF_W'(CLK_HZ / 1568);
            4'd10:   h = HALF_W'(CLK_HZ / 1760);
            4'd11:   h = HALF_W'(CLK_HZ / 1976);
            4'd12:   h = HALF_W'(CLK_HZ / 2094);
            4'd13:   h = HALF_W'(CLK_HZ / 2350);
            4'd14:   h = HALF_W'(CLK_HZ / 2638);
            default: h = '0;
        endcase
        return h;
    endfunction

    state_e            state_q, state_d;
    logic [AW-1:0]     seq_addr_d;
    logic [3:0]        note_q, note_d;
    logic              loop_q, loop_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  beeps_done_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              done_d, aborted_d;
    logic              zero_pend_q, zero_pend_d;
    logic [HALF_W-1:0] half_cnt_q, half_cnt_d;
    logic [HALF_W-1:0] half;
    logic              tone_on;
    logic              beep_d;
    logic              timer_last;

    assign busy       = (state_q != StIdle);
    assign timer_last = (timer_q == TIMER_LAST);

    // Next-state and run bookkeeping.
    always_comb begin
        state_d      = state_q;
        seq_addr_d   = seq_addr;
        note_d       = note_q;
        loop_d       = loop_q;
        count_d      = count_q;
        beeps_done_d = beeps_done;
        timer_d      = timer_q;
        done_d       = 1'b0;
        aborted_d    = 1'b0;
        zero_pend_d  = 1'b0;

        if (state_q != StIdle && stop) begin
            state_d   = StIdle;
            done_d    = 1'b1;
            aborted_d = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // A zero-length beep run reports done one cycle after acceptance.
                    if (zero_pend_q) begin
                        done_d = 1'b1;
                    end else if (!done) begin
                        if (start_mel) begin
                            seq_addr_d = '0;
                            loop_d     = loop_en;
                            state_d    = StFetch;
                        end else if (start_beep) begin
                            count_d      = beep_count;
                            beeps_done_d = '0;
                            if (beep_count == '0) begin
                                zero_pend_d = 1'b1;
                            end else begin
                                note_d  = 4'(BEEP_CODE);
                                timer_d = '0;
                                state_d = StBOn;
                            end
                        end
                    end
                end
                StFetch: begin
                    note_d = note_code;
                    if (note_code == CODE_END) begin
                        if (loop_q) begin
                            seq_addr_d = '0;
                            state_d    = StFetch;
                        end else begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end
                    end else begin
                        timer_d = '0;
                        state_d = StPlay;
                    end
                end
                StPlay: begin
                    if (timer_last) begin
                        if (seq_addr == ADDR_LAST) begin
                            if (loop_q) begin
                                seq_addr_d = '0;
                                state_d    = StFetch;
                            end else begin
                                state_d = StIdle;
                                done_d  = 1'b1;
                            end
                        end else begin
                            seq_addr_d = seq_addr + AW'(1);
                            state_d    = StFetch;
                        end
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                StBOn: begin
                    if (timer_last) begin
                        timer_d = '0;
                        state_d = StBOff;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                StBOff: begin
                    if (timer_last) begin
                        beeps_done_d = beeps_done + CNT_W'(1);
                        timer_d      = '0;
                        if (beeps_done_d == count_q) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end else begin
                            note_d  = 4'(BEEP_CODE);
                            state_d = StBOn;
                        end
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Tone generator: restarts silent at every state change, toggles each half-period.
    always_comb begin
        half       = half_of(note_q);
        tone_on    = (state_q == StPlay || state_q == StBOn) &&
                     note_q != CODE_REST && note_q != CODE_END;
        half_cnt_d = '0;
        beep_d     = IDLE_LEVEL;
        if (tone_on && state_d == state_q) begin
            if (half_cnt_q == half - HALF_W'(1)) begin
                half_cnt_d = '0;
                beep_d     = ~beep;
            end else begin
                half_cnt_d = half_cnt_q + HALF_W'(1);
                beep_d     = beep;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            seq_addr    <= '0;
            note_q      <= '0;
            loop_q      <= 1'b0;
            count_q     <= '0;
            beeps_done  <= '0;
            timer_q     <= '0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            zero_pend_q <= 1'b0;
            half_cnt_q  <= '0;
            beep        <= IDLE_LEVEL;
        end else begin
            state_q     <= state_d;
            seq_addr    <= seq_addr_d;
            note_q      <= note_d;
            loop_q      <= loop_d;
            count_q     <= count_d;
            beeps_done  <= beeps_done_d;
            timer_q     <= timer_d;
            done        <= done_d;
            aborted     <= aborted_d;
            zero_pend_q <= zero_pend_d;
            half_cnt_q  <= half_cnt_d;
            beep        <= beep_d;
        end
    end

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Self-checking bench for buzzer_sequencer: directed scenarios followed by random
// pulses, compared each cycle against an expected-waveform queue built per run.
module tb_buzzer_sequencer;

    localparam int unsigned CLK_HZ   = 24000;
    localparam int unsigned NOTE_MS  = 10;
    localparam int unsigned SEQ_LEN  = 4;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned HALF_W   = 17;
    localparam int unsigned BEEP_CD  = 5;
    localparam logic        IDLE     = 1'b1;
    localparam int unsigned AW       = 2;
    localparam int          NC       = CLK_HZ / 1000 * NOTE_MS;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_mel = 1'b0;
    logic             loop_en = 1'b0;
    logic             start_beep = 1'b0;
    logic [CNT_W-1:0] beep_count = '0;
    logic             stop = 1'b0;
    logic [AW-1:0]    seq_addr;
    logic [3:0]       note_code;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [CNT_W-1:0] beeps_done;
    logic             beep;

    logic [3:0]       rom [SEQ_LEN];

    assign note_code = rom[seq_addr];

    buzzer_sequencer #(
        .CLK_HZ    (CLK_HZ),
        .NOTE_MS   (NOTE_MS),
        .SEQ_LEN   (SEQ_LEN),
        .CNT_W     (CNT_W),
        .HALF_W    (HALF_W),
        .BEEP_CODE (BEEP_CD),
        .IDLE_LEVEL(IDLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_mel (start_mel),
        .loop_en   (loop_en),
        .start_beep(start_beep),
        .beep_count(beep_count),
        .stop      (stop),
        .seq_addr  (seq_addr),
        .note_code (note_code),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .beeps_done(beeps_done),
        .beep      (beep)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             busy;
        logic             done;
        logic             aborted;
        logic             beep;
        logic             hold;   // idle but start not yet accepted
        logic [AW-1:0]    addr;
        logic [CNT_W-1:0] bd;
    } exp_t;

    exp_t             exp_q[$];
    logic [AW-1:0]    m_addr = '0;
    logic [CNT_W-1:0] m_bd = '0;
    logic             mel_on = 1'b0;
    logic             mel_loop = 1'b0;
    logic [CNT_W-1:0] mel_bd = '0;
    int               n_checks = 0;
    int               n_errors = 0;
    int               cyc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int freq_of(input int code);
        case (code)
            1: return 330;   2: return 392;   3: return 440;   4: return 494;
            5: return 523;   6: return 587;   7: return 659;   8: return 698;
            9: return 784;  10: return 880;  11: return 988;  12: return 1047;
            13: return 1175; 14: return 1319;
            default: return 0;
        endcase
    endfunction

    // Buzzer level k cycles into a sounding step of the given code.
    function automatic logic tone(input int code, input int k);
        int half;
        if (freq_of(code) == 0) return IDLE;
        half = CLK_HZ / (2 * freq_of(code));
        return IDLE ^ logic'((k / half) % 2);
    endfunction

    function automatic exp_t mk(input logic b, input logic d, input logic a, input logic bz,
                                input logic h, input logic [AW-1:0] ad,
                                input logic [CNT_W-1:0] bd);
        exp_t e;
        e.busy = b; e.done = d; e.aborted = a; e.beep = bz; e.hold = h; e.addr = ad; e.bd = bd;
        return e;
    endfunction

    // One pass through the ROM: FETCH + NC play cycles per step until marker or last address.
    task automatic push_pass();
        int a;
        a = 0;
        forever begin
            exp_q.push_back(mk(1, 0, 0, IDLE, 0, AW'(a), mel_bd));
            if (rom[a] == 4'd15) break;
            for (int k = 0; k < NC; k++)
                exp_q.push_back(mk(1, 0, 0, tone(int'(rom[a]), k), 0, AW'(a), mel_bd));
            if (a == SEQ_LEN - 1) break;
            a++;
        end
        if (!mel_loop) begin
            exp_q.push_back(mk(0, 1, 0, IDLE, 0, AW'(a), mel_bd));
            mel_on = 1'b0;
        end
    endtask

    task automatic push_beeps(input logic [CNT_W-1:0] cnt, input logic [AW-1:0] ad);
        if (cnt == 0) begin
            exp_q.push_back(mk(0, 0, 0, IDLE, 1, ad, '0));
        end else begin
            for (int n = 0; n < int'(cnt); n++) begin
                for (int k = 0; k < NC; k++)
                    exp_q.push_back(mk(1, 0, 0, tone(BEEP_CD, k), 0, ad, CNT_W'(n)));
                for (int k = 0; k < NC; k++)
                    exp_q.push_back(mk(1, 0, 0, IDLE, 0, ad, CNT_W'(n)));
            end
        end
        exp_q.push_back(mk(0, 1, 0, IDLE, 0, ad, cnt));
    endtask

    // One clock: check this cycle's outputs, then drive inputs and extend the expectation.
    task automatic step(input logic r, input logic sm, input logic le, input logic sb,
                        input logic [CNT_W-1:0] cnt, input logic stp, input logic new_rom);
        exp_t cur;
        logic startable;
        @(negedge clk);
        cyc++;
        if (exp_q.size() > 0) begin
            cur    = exp_q.pop_front();
            m_addr = cur.addr;
            m_bd   = cur.bd;
        end else begin
            cur = mk(0, 0, 0, IDLE, 0, m_addr, m_bd);
        end
        check($sformatf("trace@%0d", cyc),
              64'({busy, done, aborted, beep, seq_addr, beeps_done}),
              64'({cur.busy, cur.done, cur.aborted, cur.beep, cur.addr, cur.bd}));
        rst        = r;
        start_mel  = sm;
        loop_en    = le;
        start_beep = sb;
        beep_count = cnt;
        stop       = stp;
        startable  = !cur.busy && !cur.done && !cur.hold;
        if (r) begin
            exp_q.delete();
            mel_on = 1'b0;
            m_addr = '0;
            m_bd   = '0;
        end else if (stp && cur.busy) begin
            exp_q.delete();
            mel_on = 1'b0;
            exp_q.push_back(mk(0, 1, 1, IDLE, 0, cur.addr, cur.bd));
        end else if (sm && startable) begin
            if (new_rom) begin
                for (int i = 0; i < SEQ_LEN; i++) begin
                    int p;
                    p = $urandom_range(0, 9);
                    rom[i] = (p < 7) ? 4'($urandom_range(1, 14)) : (p == 7) ? 4'd0 : 4'd15;
                end
            end
            mel_loop = le;
            mel_on   = 1'b1;
            mel_bd   = cur.bd;
            push_pass();
        end else if (sb && startable) begin
            push_beeps(cnt, cur.addr);
        end
        if (mel_on && mel_loop && exp_q.size() < 1000) push_pass();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, 0, 0);
    endtask

    initial begin
        rom[0] = 4'd5; rom[1] = 4'd0; rom[2] = 4'd15; rom[3] = 4'd9;
        @(negedge clk);
        check("rst_beep", 64'(beep), 64'(IDLE));
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_aborted", 64'(aborted), 64'd0);
        check("rst_addr", 64'(seq_addr), 64'd0);
        check("rst_beeps_done", 64'(beeps_done), 64'd0);
        step(1, 0, 0, 0, '0, 0, 0);
        step(0, 0, 0, 0, '0, 0, 0);

        // Melody {5,0,15}, no loop.
        step(0, 1, 0, 0, '0, 0, 0);
        idle(500);
        // Three beeps, then a zero-length beep run.
        step(0, 0, 0, 1, 16'd3, 0, 0);
        idle(1460);
        step(0, 0, 0, 1, 16'd0, 0, 0);
        idle(5);
        // Looping melody without marker, stopped mid-PLAY of the third pass.
        rom[0] = 4'd1; rom[1] = 4'd7; rom[2] = 4'd0; rom[3] = 4'd14;
        step(0, 1, 1, 0, '0, 0, 0);
        idle(2000);
        step(0, 0, 0, 0, '0, 1, 0);
        idle(5);
        // Simultaneous starts pick melody; beep start during melody ignored.
        rom[0] = 4'd2; rom[1] = 4'd3; rom[2] = 4'd15; rom[3] = 4'd1;
        step(0, 1, 0, 1, 16'd2, 0, 0);
        idle(100);
        step(0, 0, 0, 1, 16'd2, 0, 0);
        idle(500);
        // Reset while beep is low during B_ON, then stop while idle.
        step(0, 0, 0, 1, 16'd3, 0, 0);
        idle(30);
        step(1, 0, 0, 0, '0, 0, 0);
        idle(3);
        step(0, 0, 0, 0, '0, 1, 0);
        idle(5);

        // Random pulses.
        for (int i = 0; i < 24000; i++) begin
            step($urandom_range(0, 3999) == 0,
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 39) == 0,
                 CNT_W'($urandom_range(0, 3)),
                 $urandom_range(0, 599) == 0,
                 1'b1);
        end
        idle(5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/buzzer_sequencer.md
Name: buzzer_sequencer

Overview:
Parametrised tone sequencer that drives an active-low piezo buzzer. It has two modes. Melody mode plays note codes fetched from an external ROM, with optional looping. Beep mode sounds a programmable number of fixed-pitch beeps. It replaces the hard-coded alarm/beep logic; the alarm and key-control logic issue start/stop pulses and receive a done/aborted handshake.

Parameters:
CLK_HZ, 24000000, system clock frequency in Hz
NOTE_MS, 250, duration of one melody step, and of each beep on/off phase, in ms
SEQ_LEN, 64, maximum melody steps; seq_addr width AW = clog2(SEQ_LEN)
CNT_W, 16, width of beep_count and beeps_done
HALF_W, 17, tone half-period counter width; must hold CLK_HZ/660
BEEP_CODE, 5, note code used in beep mode
IDLE_LEVEL, 1, buzzer output level when silent

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start_mel  in  1  one-cycle pulse: start melody mode
loop_en  in  1  sampled at start_mel; 1 = repeat melody until stop
start_beep  in  1  one-cycle pulse: start beep mode
beep_count  in  CNT_W  number of beeps; sampled at start_beep
stop  in  1  one-cycle pulse: abort any activity
seq_addr  out  AW  melody ROM address (registered)
note_code  in  4  ROM data; valid 1 cycle after seq_addr changes
busy  out  1  high while not IDLE
done  out  1  one-cycle pulse at end of any run, normal or aborted
aborted  out  1  valid with done: 1 = ended by stop
beeps_done  out  CNT_W  beeps completed in current/last beep run
beep  out  1  buzzer drive

Behaviour:
- Single clock domain; synchronous active-high reset.
- Reset values: beep=IDLE_LEVEL, busy=0, done=0, aborted=0, seq_addr=0, beeps_done=0; FSM=IDLE. Reset mid-run silences the buzzer on the next edge, with no done pulse.
- NOTE_CYC = CLK_HZ/1000*NOTE_MS. The step timer counts 0..NOTE_CYC-1; the terminal count ends a step/phase.
- Note table: code 0 = rest; 15 = end marker.
  - Codes 1-14 map to 330, 392, 440, 494, 523, 587, 659, 698, 784, 880, 988, 1047, 1175, 1319 Hz.
  - HALF(code) = floor(CLK_HZ/(2*f)), an elaboration constant.
- Tone generator:
  - On entry to each step or beep-ON phase: half counter=0, beep=IDLE_LEVEL.
  - beep toggles when the counter reaches HALF-1, and the counter wraps to 0.
  - During a rest, OFF phase or IDLE: beep=IDLE_LEVEL.
- FSM states: IDLE, FETCH, PLAY, B_ON, B_OFF.
- IDLE + start_mel:
  - Set seq_addr=0, latch loop_en, go to FETCH; busy=1 from the next cycle.
- FETCH (1 cycle, covers the ROM latency): latch note_code.
  - Code 15: end of melody (see wrap rules).
  - Otherwise: go to PLAY.
- PLAY: play the latched code for NOTE_CYC cycles, then do one of:
  - seq_addr==SEQ_LEN-1: end of melody.
  - Otherwise: seq_addr+1, then FETCH.
- Step timing: each melody step takes NOTE_CYC+1 cycles, i.e. FETCH plus PLAY.
- End of melody:
  - loop_en latched 1: seq_addr=0, then FETCH.
  - loop_en latched 0: go to IDLE, done=1, aborted=0.
- IDLE + start_beep:
  - Latch beep_count; clear beeps_done.
  - beep_count==0: go straight to IDLE with done pulse 1 cycle later, aborted=0, no tone.
  - Otherwise: go to B_ON.
- B_ON: plays BEEP_CODE for NOTE_CYC cycles, then B_OFF.
- B_OFF: silent for NOTE_CYC cycles, then beeps_done+1.
  - If beeps_done now equals the latched count: go to IDLE with done=1, aborted=0.
  - Otherwise: go to B_ON.
- beeps_done holds its value after the run.
- stop (any non-IDLE state): go to IDLE on the next edge, beep=IDLE_LEVEL, done=1, aborted=1.
- stop in IDLE is ignored.
- Same-cycle priority: rst > stop > start_mel > start_beep.
  - Start pulses while busy are ignored.
  - A start in the same cycle as a done pulse is ignored; restarting needs busy=0 first.
- done and aborted are registered and asserted for exactly 1 cycle; aborted=0 whenever done=0.

Test Plan:
1. CLK_HZ=24000, NOTE_MS=10 (NOTE_CYC=240); ROM = {5,0,15}; start_mel, loop_en=0.
   -> Step 0: beep toggles every 22 cycles for 240 cycles.
   -> Step 1: beep held at 1 for 240 cycles.
   -> FETCH at addr 2 sees 15; done=1, aborted=0, busy=0.
2. start_beep with beep_count=3.
   -> Three 240-cycle tone bursts separated by 240-cycle silences.
   -> beeps_done steps 1, 2, 3; single done pulse after the third OFF phase.
3. start_beep with beep_count=0 -> done pulse 2 cycles after start, beep stays 1, beeps_done=0.
4. loop_en=1 with a 4-entry ROM without marker (SEQ_LEN=4).
   -> seq_addr cycles 0,1,2,3,0,… with no done.
   -> stop mid-PLAY: next cycle beep=1, busy=0, done=1, aborted=1.
5. start_mel and start_beep asserted in the same cycle -> melody mode runs. start_beep pulse during melody -> ignored, beeps_done unchanged.
6. rst asserted during B_ON with beep=0 -> next cycle beep=1, busy=0, beeps_done=0, no done pulse; stop pulse in IDLE produces no done.
